// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  typedef enum logic [2:0] {StIdle, StArm, StUp, StGap, StOver} state_e;

  // Fibonacci feedback taps 8,6,5,4; bit 7 is tap 8.
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; also returns its low bits folded into 0..NUM_MOLES-1.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int unsigned NUM_MOLES = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned IDX_W     = clog2(NUM_MOLES)
) (
  input  logic             clkglobal,
  input  logic             resetglobal,
  output logic [7:0]       lfsr,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] NumMoles = (IDX_W + 1)'(NUM_MOLES);

  logic [IDX_W:0] raw;

  always_ff @(posedge clkglobal or posedge resetglobal) begin
    if (resetglobal) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LfsrTaps)};
    end
  end

  always_comb begin
    raw = {1'b0, lfsr[IDX_W-1:0]};
    if (raw >= NumMoles) raw = raw - NumMoles;
    idx = raw[IDX_W-1:0];
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller driven by the difficulty tick.
// Optional: define WRONG_WHACK_PENALTY_EN to charge a miss for a wrong button while a mole is up.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned NUM_MOLES = 8,
  parameter int unsigned WIN_TICKS = 3,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned LIVES     = 5,
  parameter int unsigned SCORE_W   = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                 clkglobal,
  input  logic                 resetglobal,
  input  logic                 resetlocal,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  output logic [NUM_MOLES-1:0] mole,
  output logic                 hit_p,
  output logic                 miss_p,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           lives,
  output logic                 game_over
);

  localparam int unsigned IdxW    = clog2(NUM_MOLES);
  localparam int unsigned MaxTick = (WIN_TICKS > GAP_TICKS) ? WIN_TICKS : GAP_TICKS;
  localparam int unsigned CntW    = clog2(MaxTick + 1);
  localparam logic [CntW-1:0]      WinLast   = CntW'(WIN_TICKS - 1);
  localparam logic [CntW-1:0]      GapLast   = CntW'(GAP_TICKS - 1);
  localparam logic [3:0]           LivesInit = 4'(LIVES);
  localparam logic [IdxW-1:0]      IdxLast   = IdxW'(NUM_MOLES - 1);
  localparam logic [NUM_MOLES-1:0] OneHot0   = NUM_MOLES'(1);

  logic                 tick_s1, tick_s2, tick_s3, tick_p;
  logic [NUM_MOLES-1:0] btn_q, btn_qq, bp;
  logic [7:0]           lfsr_val;
  logic [IdxW-1:0]      lfsr_idx, idx_inc, idx_sel, idx_q;
  logic                 prev_vld_q;
  logic [CntW-1:0]      cnt_q;
  logic                 hit, expire;
  state_e               state_q;

  mole_lfsr #(
    .NUM_MOLES(NUM_MOLES),
    .LFSR_SEED(LFSR_SEED),
    .IDX_W    (IdxW)
  ) u_lfsr (
    .clkglobal  (clkglobal),
    .resetglobal(resetglobal),
    .lfsr       (lfsr_val),
    .idx        (lfsr_idx)
  );

  // A zero state would lock the LFSR up for good.
  assert property (@(posedge clkglobal) disable iff (resetglobal) lfsr_val != 8'h00);

  always_ff @(posedge clkglobal or posedge resetglobal) begin
    if (resetglobal) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
      btn_q   <= '0;
      btn_qq  <= '0;
    end else begin
      tick_s1 <= tick;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
      btn_q   <= btn;
      btn_qq  <= btn_q;
    end
  end

  assign tick_p = tick_s2 & ~tick_s3;
  assign bp     = btn_q & ~btn_qq;

  always_comb begin
    idx_inc = (lfsr_idx == IdxLast) ? '0 : lfsr_idx + IdxW'(1);
    // Never raise the same mole twice in a row.
    idx_sel = (prev_vld_q && lfsr_idx == idx_q) ? idx_inc : lfsr_idx;
    hit     = bp[idx_q];
    expire  = tick_p && (cnt_q == WinLast);
`ifdef WRONG_WHACK_PENALTY_EN
    expire  = expire || (|(bp & ~(OneHot0 << idx_q)));
`endif
  end

  always_ff @(posedge clkglobal or posedge resetglobal) begin
    if (resetglobal) begin
      state_q    <= StIdle;
      mole       <= '0;
      hit_p      <= 1'b0;
      miss_p     <= 1'b0;
      score      <= '0;
      lives      <= LivesInit;
      game_over  <= 1'b0;
      idx_q      <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hit_p  <= 1'b0;
      miss_p <= 1'b0;
      if (resetlocal) begin
        state_q   <= StIdle;
        mole      <= '0;
        score     <= '0;
        lives     <= LivesInit;
        game_over <= 1'b0;
        cnt_q     <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            mole <= '0;
            if (start) state_q <= StArm;
          end
          StArm: begin
            idx_q      <= idx_sel;
            prev_vld_q <= 1'b1;
            mole       <= OneHot0 << idx_sel;
            cnt_q      <= '0;
            state_q    <= StUp;
          end
          StUp: begin
            // A hit in the same cycle as the expiring tick takes priority.
            if (hit) begin
              hit_p   <= 1'b1;
              if (score != '1) score <= score + SCORE_W'(1);
              mole    <= '0;
              cnt_q   <= '0;
              state_q <= StGap;
            end else if (expire) begin
              miss_p <= 1'b1;
              lives  <= lives - 4'd1;
              mole   <= '0;
              cnt_q  <= '0;
              if (lives == 4'd1) begin
                state_q   <= StOver;
                game_over <= 1'b1;
              end else begin
                state_q <= StGap;
              end
            end else if (tick_p) begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StGap: begin
            if (tick_p) begin
              if (cnt_q == GapLast) begin
                cnt_q   <= '0;
                state_q <= StArm;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StOver: begin
            game_over <= 1'b1;
            mole      <= '0;
            if (start) begin
              lives     <= LivesInit;
              score     <= '0;
              game_over <= 1'b0;
              state_q   <= StArm;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: a cycle-level rules model checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_mole_round_ctrl;

  localparam int N   = 8;
  localparam int SW  = 3;
  localparam int L   = 5;
  localparam int WIN = 3;
  localparam int GAP = 1;

  localparam int PIdle = 0, PArm = 1, PUp = 2, PGap = 3, POver = 4;

  logic         clkglobal   = 1'b0;
  logic         resetglobal = 1'b1;
  logic         resetlocal  = 1'b0;
  logic         tick        = 1'b0;
  logic         start       = 1'b0;
  logic [N-1:0] btn         = '0;
  logic [N-1:0] mole;
  logic         hit_p, miss_p, game_over;
  logic [SW-1:0] score;
  logic [3:0]   lives;

  mole_round_ctrl #(
    .NUM_MOLES(N),
    .WIN_TICKS(WIN),
    .GAP_TICKS(GAP),
    .LIVES    (L),
    .SCORE_W  (SW),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clkglobal  (clkglobal),
    .resetglobal(resetglobal),
    .resetlocal (resetlocal),
    .tick       (tick),
    .start      (start),
    .btn        (btn),
    .mole       (mole),
    .hit_p      (hit_p),
    .miss_p     (miss_p),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clkglobal = ~clkglobal;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: plain integers describing the game as the rules state it.
  int m_lfsr = 'hA5;
  int m_phase = PIdle;
  int m_score = 0, m_lives = L, m_ticks = 0, m_idx = 0;
  int m_mole = 0, m_hit = 0, m_miss = 0, m_over = 0;
  bit m_have_prev = 1'b0;
  bit th0 = 1'b0, th1 = 1'b0, th2 = 1'b0;
  logic [N-1:0] bh0 = '0, bh1 = '0;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 'hFF;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clkglobal) begin
    bit tp, wrong;
    logic [N-1:0] bpv, hot;
    int r;
    if (resetglobal) begin
      m_lfsr = 'hA5; m_phase = PIdle; m_score = 0; m_lives = L; m_ticks = 0;
      m_mole = 0; m_hit = 0; m_miss = 0; m_over = 0; m_have_prev = 1'b0; m_idx = 0;
      th0 = 1'b0; th1 = 1'b0; th2 = 1'b0; bh0 = '0; bh1 = '0;
    end else begin
      // Tick edge becomes usable two cycles after sampling; button edge one cycle after.
      tp    = th1 & ~th2;
      bpv   = bh0 & ~bh1;
      hot   = N'(1) << m_idx;
      wrong = 1'b0;
`ifdef WRONG_WHACK_PENALTY_EN
      wrong = |(bpv & ~hot);
`endif
      m_hit  = 0;
      m_miss = 0;
      if (resetlocal) begin
        m_phase = PIdle; m_score = 0; m_lives = L; m_mole = 0; m_over = 0; m_ticks = 0;
      end else begin
        case (m_phase)
          PIdle: if (start) m_phase = PArm;
          PArm: begin
            r = m_lfsr % 8;
            if (r >= N) r = r - N;
            if (m_have_prev && r == m_idx) r = (r + 1) % N;
            m_idx = r; m_have_prev = 1'b1; m_mole = 1 << r; m_ticks = 0; m_phase = PUp;
          end
          PUp: begin
            if (bpv[m_idx]) begin
              m_hit = 1;
              if (m_score < (1 << SW) - 1) m_score++;
              m_mole = 0; m_ticks = 0; m_phase = PGap;
            end else begin
              if (tp) m_ticks++;
              if (m_ticks == WIN || wrong) begin
                m_miss = 1; m_lives--; m_mole = 0; m_ticks = 0;
                m_phase = (m_lives == 0) ? POver : PGap;
                m_over = (m_lives == 0) ? 1 : 0;
              end
            end
          end
          PGap: begin
            if (tp) m_ticks++;
            if (m_ticks == GAP) begin m_ticks = 0; m_phase = PArm; end
          end
          POver: if (start) begin
            m_lives = L; m_score = 0; m_over = 0; m_phase = PArm;
          end
          default: m_phase = PIdle;
        endcase
      end
      m_lfsr = lfsr_next(m_lfsr);
      th2 = th1; th1 = th0; th0 = tick;
      bh1 = bh0; bh0 = btn;
    end
  end

  always @(negedge clkglobal) begin
    if (chk_en && !resetglobal) begin
      chk("mole", int'(mole), m_mole);
      chk("hit_p", int'(hit_p), m_hit);
      chk("miss_p", int'(miss_p), m_miss);
      chk("score", int'(score), m_score);
      chk("lives", int'(lives), m_lives);
      chk("game_over", int'(game_over), m_over);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clkglobal);
  endtask

  task automatic tick_pulse();
    tick = 1'b1; cyc(3);
    tick = 1'b0; cyc(3);
  endtask

  task automatic press(input int i);
    btn[i] = 1'b1; cyc(2);
    btn = '0; cyc(2);
  endtask

  initial begin
    int first_idx;
    cyc(3);
    chk("rst_mole", int'(mole), 0);
    chk("rst_lives", int'(lives), 5);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_pulses", int'({hit_p, miss_p}), 0);
    chk("model_seed", m_lfsr, 'hA5);

    // 1: first round from seed A5 lands on index 2
    resetglobal = 1'b0; start = 1'b1; chk_en = 1'b1;
    cyc(1); start = 1'b0;
    cyc(1);
    chk("t1_mole", int'(mole), 'h04);
    chk("model_lfsr_2", m_lfsr, 'h95);
    chk("t1_lives", int'(lives), 5);
    chk("t1_score", int'(score), 0);

    // 2: hit, ignored press in GAP, next mole elsewhere
    cyc(2);
    first_idx = m_idx;
    press(m_idx);
    chk("t2_score", int'(score), 1);
    press(first_idx);
    tick_pulse();
    chk("t2_mole_up", int'(mole != '0), 1);
    chk("t2_mole_moved", int'(mole[first_idx]), 0);

    // 3: timeout after three tick edges
    repeat (3) tick_pulse();
    chk("t3_lives", int'(lives), 4);
    tick_pulse();

    // 4: run out of lives, then restart
    repeat (4) begin
      repeat (3) tick_pulse();
      tick_pulse();
    end
    chk("t4_over", int'(game_over), 1);
    chk("t4_lives", int'(lives), 0);
    chk("t4_mole", int'(mole), 0);
    start = 1'b1; cyc(1); start = 1'b0; cyc(2);
    chk("t4_restart_lives", int'(lives), 5);
    chk("t4_restart_score", int'(score), 0);
    chk("t4_restart_up", int'(mole != '0), 1);

    // 5: hit lands on the expiring tick; start held in UP/GAP is ignored
    start = 1'b1;
    tick_pulse();
    tick_pulse();
    tick = 1'b1; cyc(1);
    btn[m_idx] = 1'b1; cyc(3);
    tick = 1'b0; btn = '0; cyc(3);
    start = 1'b0;
    chk("t5_lives", int'(lives), 5);
    chk("t5_score", int'(score), 1);
    tick_pulse();

    // score saturation at all-ones
    repeat (8) begin
      press(m_idx);
      tick_pulse();
    end
    chk("t5_score_sat", int'(score), 7);

    // 6: wrong button, then local reset while a mole is up
    press((m_idx + 1) % N);
`ifdef WRONG_WHACK_PENALTY_EN
    chk("t6_wrong_lives", int'(lives), 4);
    chk("t6_wrong_mole", int'(mole != '0), 0);
    tick_pulse();
`else
    chk("t6_wrong_lives", int'(lives), 5);
    chk("t6_wrong_mole", int'(mole != '0), 1);
`endif
    resetlocal = 1'b1; cyc(1); resetlocal = 1'b0;
    chk("t6_rl_score", int'(score), 0);
    chk("t6_rl_lives", int'(lives), 5);
    chk("t6_rl_mole", int'(mole), 0);
    press(0);
    start = 1'b1; cyc(1); start = 1'b0; cyc(3);
    chk("t6_new_round", int'(mole != '0), 1);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
